// File: rtl/rename_rat.sv
// rename_rat: rename stage. It keeps the speculative RAT, takes dst tags from the free list
// in the same cycle and bypasses within a group. Optional feature macro: RENAME_FLUSH_EN.
module rename_rat #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int MAX_IO    = 3,
    parameter int ZERO_REG  = 31,
    localparam int AR_BITS  = $clog2(ARCH_REGS),
    localparam int PR_BITS  = $clog2(PHYS_REGS)
) (
    input  logic                              clk,
    input  logic                              rst,
`ifdef RENAME_FLUSH_EN
    input  logic                              flush,
    input  logic [MAX_IO-1:0]                 commit_en,
    input  logic [MAX_IO-1:0][AR_BITS-1:0]    commit_dst_arch,
    input  logic [MAX_IO-1:0][PR_BITS-1:0]    commit_dst_phys,
`endif
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [MAX_IO-1:0]                 in_slot_valid,
    input  logic [MAX_IO-1:0]                 in_dst_en,
    input  logic [MAX_IO-1:0][AR_BITS-1:0]    in_dst_arch,
    input  logic [MAX_IO-1:0][AR_BITS-1:0]    in_src1_arch,
    input  logic [MAX_IO-1:0][AR_BITS-1:0]    in_src2_arch,
    output logic [MAX_IO-1:0]                 fl_get_en,
    input  logic [MAX_IO-1:0][PR_BITS-1:0]    fl_tag,
    input  logic [PR_BITS:0]                  fl_len,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MAX_IO-1:0]                 out_slot_valid,
    output logic [MAX_IO-1:0]                 out_dst_en,
    output logic [MAX_IO-1:0][PR_BITS-1:0]    out_dst_phys,
    output logic [MAX_IO-1:0][PR_BITS-1:0]    out_old_phys,
    output logic [MAX_IO-1:0][PR_BITS-1:0]    out_src1_phys,
    output logic [MAX_IO-1:0][PR_BITS-1:0]    out_src2_phys
);
    localparam logic [AR_BITS-1:0] ZR = AR_BITS'(ZERO_REG);
    localparam int KW = $clog2(MAX_IO + 1);

    typedef struct packed {
        logic               vld;
        logic               dst_en;
        logic [PR_BITS-1:0] dst;
        logic [PR_BITS-1:0] old;
        logic [PR_BITS-1:0] src1;
        logic [PR_BITS-1:0] src2;
    } slot_t;

    logic [MAX_IO-1:0]                  need;
    logic [PR_BITS:0]                   n_need;
    logic                               accept;
    logic                               flush_w;
    logic [KW-1:0]                      k;
    logic [MAX_IO-1:0][PR_BITS-1:0]     new_tag;
    logic [MAX_IO-1:0][PR_BITS-1:0]     src1_m, src2_m, old_m;
    slot_t [MAX_IO-1:0]                 slot_d, slot_q;
    logic                               out_valid_q;
    logic [ARCH_REGS-1:0][PR_BITS-1:0]  rat_d, rat_q;

`ifdef RENAME_FLUSH_EN
    logic [ARCH_REGS-1:0][PR_BITS-1:0]  ret_d, ret_q;

    assign flush_w = flush;

    // Commits apply in slot order so the highest slot wins on a shared arch reg.
    always_comb begin
        ret_d = ret_q;
        for (int i = 0; i < MAX_IO; i++) begin
            if (commit_en[i]) ret_d[commit_dst_arch[i]] = commit_dst_phys[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) ret_q[i] <= PR_BITS'(i);
        end else begin
            ret_q <= ret_d;
        end
    end
`else
    assign flush_w = 1'b0;
`endif

    always_comb begin
        n_need = '0;
        for (int i = 0; i < MAX_IO; i++) begin
            need[i] = in_slot_valid[i] && in_dst_en[i] && (in_dst_arch[i] != ZR);
            n_need  = n_need + {{PR_BITS{1'b0}}, need[i]};
        end
    end

    assign in_ready  = rst && !flush_w && (!out_valid_q || out_ready) && (n_need <= fl_len);
    assign accept    = in_valid && in_ready;
    assign fl_get_en = accept ? need : '0;

    // Free-list tags are compacted, so slot i uses the tag at its prefix count of needs.
    always_comb begin
        k = '0;
        for (int i = 0; i < MAX_IO; i++) begin
            new_tag[i] = fl_tag[k];
            if (need[i]) k = k + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_IO; i++) begin
            src1_m[i] = rat_q[in_src1_arch[i]];
            src2_m[i] = rat_q[in_src2_arch[i]];
            old_m[i]  = rat_q[in_dst_arch[i]];
            for (int j = 0; j < i; j++) begin
                if (need[j] && in_dst_arch[j] == in_src1_arch[i]) src1_m[i] = new_tag[j];
                if (need[j] && in_dst_arch[j] == in_src2_arch[i]) src2_m[i] = new_tag[j];
                if (need[j] && in_dst_arch[j] == in_dst_arch[i])  old_m[i]  = new_tag[j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_IO; i++) begin
            slot_d[i] = '0;
            if (in_slot_valid[i]) begin
                slot_d[i].vld    = 1'b1;
                slot_d[i].dst_en = need[i];
                slot_d[i].src1   = src1_m[i];
                slot_d[i].src2   = src2_m[i];
                if (need[i]) begin
                    slot_d[i].dst = new_tag[i];
                    slot_d[i].old = old_m[i];
                end
            end
        end
    end

    // Youngest writer in the group wins because later slots overwrite earlier ones.
    always_comb begin
        rat_d = rat_q;
        if (accept) begin
            for (int i = 0; i < MAX_IO; i++) begin
                if (need[i]) rat_d[in_dst_arch[i]] = new_tag[i];
            end
        end
`ifdef RENAME_FLUSH_EN
        if (flush) rat_d = ret_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= PR_BITS'(i);
            out_valid_q <= 1'b0;
            slot_q      <= '0;
        end else begin
            rat_q <= rat_d;
            if (flush_w) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                slot_q      <= slot_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;

    for (genvar g = 0; g < MAX_IO; g++) begin : g_out
        assign out_slot_valid[g] = slot_q[g].vld;
        assign out_dst_en[g]     = slot_q[g].dst_en;
        assign out_dst_phys[g]   = slot_q[g].dst;
        assign out_old_phys[g]   = slot_q[g].old;
        assign out_src1_phys[g]  = slot_q[g].src1;
        assign out_src2_phys[g]  = slot_q[g].src2;
    end

endmodule

// File: tb/tb_rename_rat.sv
// tb_rename_rat: directed rename scenarios plus random groups checked against a
// slot-by-slot map walk model.
module tb_rename_rat;
    localparam int AR = 5, PR = 6, N = 3, ZR = 31, NA = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic                  in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0]          in_slot_valid, in_dst_en, fl_get_en, out_slot_valid, out_dst_en;
    logic [N-1:0][AR-1:0]  in_dst_arch, in_src1_arch, in_src2_arch;
    logic [N-1:0][PR-1:0]  fl_tag, out_dst_phys, out_old_phys, out_src1_phys, out_src2_phys;
    logic [PR:0]           fl_len;
`ifdef RENAME_FLUSH_EN
    logic                  flush;
    logic [N-1:0]          commit_en;
    logic [N-1:0][AR-1:0]  commit_dst_arch;
    logic [N-1:0][PR-1:0]  commit_dst_phys;
`endif

    rename_rat dut (
        .clk(clk), .rst(rst),
`ifdef RENAME_FLUSH_EN
        .flush(flush), .commit_en(commit_en),
        .commit_dst_arch(commit_dst_arch), .commit_dst_phys(commit_dst_phys),
`endif
        .in_valid(in_valid), .in_ready(in_ready),
        .in_slot_valid(in_slot_valid), .in_dst_en(in_dst_en),
        .in_dst_arch(in_dst_arch), .in_src1_arch(in_src1_arch), .in_src2_arch(in_src2_arch),
        .fl_get_en(fl_get_en), .fl_tag(fl_tag), .fl_len(fl_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_slot_valid(out_slot_valid), .out_dst_en(out_dst_en),
        .out_dst_phys(out_dst_phys), .out_old_phys(out_old_phys),
        .out_src1_phys(out_src1_phys), .out_src2_phys(out_src2_phys)
    );

    int n_chk = 0, n_err = 0;

    // Reference model state
    int m_rat[NA], m_ret[NA], w[NA];
    bit ev, acc;
    int e_sv[N], e_de[N], e_dp[N], e_op[N], e_s1[N], e_s2[N];
    int g_sv[N], g_de[N], g_dp[N], g_op[N], g_s1[N], g_s2[N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        in_valid = 1'b0; in_slot_valid = '0; in_dst_en = '0;
        in_dst_arch = '0; in_src1_arch = '0; in_src2_arch = '0;
        fl_tag = '0; fl_len = 7'd64; out_ready = 1'b1;
`ifdef RENAME_FLUSH_EN
        flush = 1'b0; commit_en = '0; commit_dst_arch = '0; commit_dst_phys = '0;
`endif
    endtask

    task automatic set_slot(input int i, input bit de, input int d, input int s1, input int s2);
        in_slot_valid[i] = 1'b1;
        in_dst_en[i]     = de;
        in_dst_arch[i]   = AR'(d);
        in_src1_arch[i]  = AR'(s1);
        in_src2_arch[i]  = AR'(s2);
    endtask

    task automatic check_outs();
        chk("out_valid", out_valid, ev);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("slot_valid%0d", i), out_slot_valid[i], e_sv[i]);
            chk($sformatf("dst_en%0d", i),     out_dst_en[i],     e_de[i]);
            chk($sformatf("dst_phys%0d", i),   out_dst_phys[i],   e_dp[i]);
            chk($sformatf("old_phys%0d", i),   out_old_phys[i],   e_op[i]);
            chk($sformatf("src1_phys%0d", i),  out_src1_phys[i],  e_s1[i]);
            chk($sformatf("src2_phys%0d", i),  out_src2_phys[i],  e_s2[i]);
        end
    endtask

    // Walk the slots in program order over a working copy of the map.
    task automatic model_comb();
        int nn;
        int q[$];
        bit nd[N];
        bit rdy;
        logic [N-1:0] eg;
        nn = 0;
        for (int i = 0; i < N; i++) begin
            nd[i] = in_slot_valid[i] && in_dst_en[i] && (int'(in_dst_arch[i]) != ZR);
            nn += int'(nd[i]);
        end
        rdy = (!ev || out_ready) && (nn <= int'(fl_len));
`ifdef RENAME_FLUSH_EN
        if (flush) rdy = 1'b0;
`endif
        acc = in_valid && rdy;
        eg = '0;
        for (int i = 0; i < N; i++) eg[i] = acc && nd[i];
        chk("in_ready", in_ready, rdy);
        chk("fl_get_en", fl_get_en, eg);
        w = m_rat;
        for (int i = 0; i < N; i++) q.push_back(int'(fl_tag[i]));
        for (int i = 0; i < N; i++) begin
            g_sv[i] = 0; g_de[i] = 0; g_dp[i] = 0; g_op[i] = 0; g_s1[i] = 0; g_s2[i] = 0;
            if (in_slot_valid[i]) begin
                g_sv[i] = 1;
                g_s1[i] = w[in_src1_arch[i]];
                g_s2[i] = w[in_src2_arch[i]];
                if (nd[i]) begin
                    g_de[i] = 1;
                    g_dp[i] = q.pop_front();
                    g_op[i] = w[in_dst_arch[i]];
                    w[in_dst_arch[i]] = g_dp[i];
                end
            end
        end
    endtask

    task automatic model_seq();
        bit fl;
        fl = 1'b0;
`ifdef RENAME_FLUSH_EN
        for (int i = 0; i < N; i++)
            if (commit_en[i]) m_ret[commit_dst_arch[i]] = int'(commit_dst_phys[i]);
        fl = flush;
`endif
        if (fl) begin
            m_rat = m_ret;
            ev = 1'b0;
        end else if (acc) begin
            m_rat = w;
            ev = 1'b1;
            e_sv = g_sv; e_de = g_de; e_dp = g_dp; e_op = g_op; e_s1 = g_s1; e_s2 = g_s2;
        end else if (out_ready) begin
            ev = 1'b0;
        end
    endtask

    // Called just after a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        #1;
        model_comb();
        @(posedge clk);
        #1;
        model_seq();
        check_outs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b0;
        in_valid = 1'b1;
        set_slot(0, 1, 3, 1, 2);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_fl_get_en", fl_get_en, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < NA; i++) begin
            m_rat[i] = i;
            m_ret[i] = i;
        end
        ev = 1'b0;
        for (int i = 0; i < N; i++) begin
            e_sv[i] = 0; e_de[i] = 0; e_dp[i] = 0; e_op[i] = 0; e_s1[i] = 0; e_s2[i] = 0;
        end
        check_outs();
        @(negedge clk);
        rst = 1'b1;
        clear_in();
    endtask

    function automatic logic [AR-1:0] pick_arch();
        return ($urandom_range(0, 7) == 0) ? AR'(ZR) : AR'($urandom_range(0, 7));
    endfunction

    initial begin
        clear_in();
        @(negedge clk);

        // 1: single slot r1=r2+r3
        do_reset();
        in_valid = 1'b1; set_slot(0, 1, 1, 2, 3); fl_tag[0] = 6'd17;
        #1 chk("t1_get", fl_get_en, 3'b001);
        cycle();
        chk("t1_dst", out_dst_phys[0], 17);
        chk("t1_old", out_old_phys[0], 1);
        chk("t1_src", {out_src1_phys[0], out_src2_phys[0]}, {6'd2, 6'd3});

        // 2: intra-group RAW/WAW
        do_reset();
        in_valid = 1'b1;
        set_slot(0, 1, 1, 2, 2); set_slot(1, 1, 4, 1, 1); set_slot(2, 1, 1, 4, 0);
        fl_tag[0] = 6'd40; fl_tag[1] = 6'd41; fl_tag[2] = 6'd42; fl_len = 7'd3;
        cycle();
        chk("t2_s1_1", out_src1_phys[1], 40);
        chk("t2_s1_2", out_src1_phys[2], 41);
        chk("t2_s2_2", out_src2_phys[2], 0);
        chk("t2_old2", out_old_phys[2], 40);
        clear_in(); in_valid = 1'b1; set_slot(0, 0, 0, 1, 4);
        cycle();
        chk("t2_rat1", out_src1_phys[0], 42);
        chk("t2_rat4", out_src2_phys[0], 41);

        // 3: free-list shortfall stalls the whole group
        do_reset();
        in_valid = 1'b1;
        set_slot(0, 1, 1, 2, 2); set_slot(1, 1, 4, 1, 1); set_slot(2, 1, 1, 4, 0);
        fl_tag[0] = 6'd40; fl_tag[1] = 6'd41; fl_tag[2] = 6'd42; fl_len = 7'd2;
        #1 chk("t3_stall", in_ready, 0);
        cycle();
        fl_len = 7'd3;
        cycle();
        chk("t3_old0", out_old_phys[0], 1);
        chk("t3_valid", out_valid, 1);

        // 4: zero-reg destination, empty free list
        clear_in(); in_valid = 1'b1; set_slot(0, 1, ZR, 5, 6); fl_len = '0;
        cycle();
        chk("t4_dst_en", out_dst_en[0], 0);
        clear_in(); in_valid = 1'b1; set_slot(0, 0, 0, ZR, ZR);
        cycle();
        chk("t4_src_zr", out_src1_phys[0], 31);

        // 5: backpressure hold, then back-to-back groups
        clear_in(); in_valid = 1'b1; set_slot(0, 1, 2, 3, 4); fl_tag[0] = 6'd50;
        cycle();
        out_ready = 1'b0; set_slot(0, 1, 5, 2, 2); fl_tag[0] = 6'd51;
        for (int c = 0; c < 3; c++) cycle();
        chk("t5_held", out_dst_phys[0], 50);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            fl_tag[0] = PR'(52 + c);
            #1 chk("t5_b2b_rdy", in_ready, 1);
            cycle();
        end

`ifdef RENAME_FLUSH_EN
        // 6: flush restores the retirement map including same-cycle commits
        do_reset();
        in_valid = 1'b1; set_slot(0, 1, 1, 2, 3); fl_tag[0] = 6'd40;
        cycle();
        clear_in(); in_valid = 1'b1; set_slot(0, 1, 7, 1, 1);
        commit_en[0] = 1'b1; commit_dst_arch[0] = 5'd1; commit_dst_phys[0] = 6'd50; flush = 1'b1;
        cycle();
        chk("t6_flush_valid", out_valid, 0);
        clear_in(); in_valid = 1'b1; set_slot(0, 0, 0, 1, 1);
        cycle();
        chk("t6_src_ret", out_src1_phys[0], 50);
`endif

        // Random groups
        do_reset();
        for (int c = 0; c < 500; c++) begin
            int n;
            n = $urandom_range(0, N);
            in_valid = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                in_slot_valid[i] = (i < n);
                in_dst_en[i]     = ($urandom_range(0, 3) != 0);
                in_dst_arch[i]   = pick_arch();
                in_src1_arch[i]  = pick_arch();
                in_src2_arch[i]  = pick_arch();
                fl_tag[i]        = PR'($urandom_range(0, 63));
            end
            fl_len    = ($urandom_range(0, 3) == 0) ? (PR+1)'($urandom_range(0, 3)) : 7'd64;
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef RENAME_FLUSH_EN
            flush = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) begin
                commit_en[i]       = ($urandom_range(0, 2) == 0);
                commit_dst_arch[i] = pick_arch();
                commit_dst_phys[i] = PR'($urandom_range(0, 63));
            end
`endif
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
